// File: rtl/axis_rx_frame_checker_if.sv
// AXI-Stream bundle between the MAC RX FIFO and the frame checker.
// The master drives the beat, and the slave returns tready.
interface axis_rx_frame_checker_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axis_rx_frame_checker.sv
// RX-side AXI-Stream sink. It counts frames, bytes, bad frames and runts,
// checks a per-frame sequence number and drives a stretched activity LED.
module axis_rx_frame_checker #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned SEQ_WORD    = 6,
  parameter int unsigned MIN_LEN     = 60,
  parameter int unsigned LED_STRETCH = 15625000
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_rx_frame_checker_if.slave        s_axis,
  input  logic                          clear,
  output logic [31:0]                   frame_count,
  output logic [63:0]                   byte_count,
  output logic [31:0]                   bad_frame_count,
  output logic [31:0]                   runt_count,
  output logic [31:0]                   seq_error_count,
  output logic [15:0]                   last_len,
  output logic                          seq_locked,
  output logic                          act_led
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LED_W      = $clog2(LED_STRETCH + 1);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  function automatic logic [3:0] f_popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + {3'b000, keep[i]};
    end
    return cnt;
  endfunction

  state_t             r_state;
  logic               r_tready;
  logic [7:0]         r_beat_idx;
  logic [15:0]        r_len_acc;
  logic [31:0]        r_seq_cap;
  logic               r_has_seq;
  logic [31:0]        r_expected;
  logic               r_seq_locked;
  logic [31:0]        r_frame_count;
  logic [63:0]        r_byte_count;
  logic [31:0]        r_bad_count;
  logic [31:0]        r_runt_count;
  logic [31:0]        r_seq_err_count;
  logic [15:0]        r_last_len;
  logic [LED_W-1:0]   r_led_cnt;
  logic               r_act_led;

  logic               w_accept;
  logic               w_first;
  logic [7:0]         w_cur_idx;
  logic [7:0]         w_next_idx;
  logic [15:0]        w_base_len;
  logic [16:0]        w_sum;
  logic [15:0]        w_len;
  logic               w_is_seq_beat;
  logic               w_has_seq;
  logic [31:0]        w_seq;
  logic               w_eof;
  logic               w_good;
  logic               w_bad;
  logic               w_seq_chk;
  logic               w_seq_err;
  logic               w_locked_base;

  // The first beat of a frame is seen while still in IDLE, so index, length
  // and has_seq are taken as zero there rather than from the registers.
  always_comb begin
    w_accept      = s_axis.tvalid & r_tready;
    w_first       = (r_state == ST_IDLE);
    w_cur_idx     = w_first ? '0 : r_beat_idx;
    w_next_idx    = (w_cur_idx == 8'hFF) ? 8'hFF : w_cur_idx + 8'd1;
    w_base_len    = w_first ? '0 : r_len_acc;
    w_sum         = {1'b0, w_base_len} + {13'd0, f_popcount(s_axis.tkeep)};
    w_len         = w_sum[16] ? '1 : w_sum[15:0];
    w_is_seq_beat = (w_cur_idx == 8'(SEQ_WORD));
    w_has_seq     = w_is_seq_beat | (~w_first & r_has_seq);
    w_seq         = w_is_seq_beat ? s_axis.tdata[31:0] : r_seq_cap;
    w_eof         = w_accept & s_axis.tlast;
    w_good        = w_eof & ~s_axis.tuser;
    w_bad         = w_eof & s_axis.tuser;
    w_locked_base = clear ? 1'b0 : r_seq_locked;
    w_seq_chk     = w_good & w_has_seq;
    w_seq_err     = w_seq_chk & w_locked_base & (w_seq != r_expected);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tready   <= 1'b0;
      r_beat_idx <= '0;
      r_len_acc  <= '0;
      r_seq_cap  <= '0;
      r_has_seq  <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_accept) begin
        r_beat_idx <= w_next_idx;
        r_len_acc  <= w_len;
        r_seq_cap  <= w_seq;
        r_has_seq  <= w_has_seq;
        r_state    <= s_axis.tlast ? ST_IDLE : ST_BODY;
      end
    end
  end

  // A coincident clear supplies a zero base; the frame's update still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count   <= '0;
      r_byte_count    <= '0;
      r_bad_count     <= '0;
      r_runt_count    <= '0;
      r_seq_err_count <= '0;
      r_last_len      <= '0;
      r_seq_locked    <= 1'b0;
      r_expected      <= '0;
    end else begin
      r_frame_count   <= (clear ? '0 : r_frame_count) + {31'd0, w_good};
      r_byte_count    <= (clear ? '0 : r_byte_count) + (w_good ? {48'd0, w_len} : '0);
      r_bad_count     <= (clear ? '0 : r_bad_count) + {31'd0, w_bad};
      r_runt_count    <= (clear ? '0 : r_runt_count)
                         + {31'd0, (w_good && (w_len < 16'(MIN_LEN)))};
      r_seq_err_count <= (clear ? '0 : r_seq_err_count) + {31'd0, w_seq_err};
      if (w_good) begin
        r_last_len <= w_len;
      end else if (clear) begin
        r_last_len <= '0;
      end
      if (w_seq_chk) begin
        r_seq_locked <= 1'b1;
        r_expected   <= w_seq + 32'd1;
      end else begin
        r_seq_locked <= w_locked_base;
      end
    end
  end

  // The LED drops one cycle after the counter reaches zero, giving
  // LED_STRETCH lit cycles per good frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_cnt <= '0;
      r_act_led <= 1'b0;
    end else if (w_good) begin
      r_led_cnt <= LED_W'(LED_STRETCH - 1);
      r_act_led <= 1'b1;
    end else if (r_led_cnt != '0) begin
      r_led_cnt <= r_led_cnt - 1'b1;
    end else begin
      r_act_led <= 1'b0;
    end
  end

  assign s_axis.tready   = r_tready;
  assign frame_count     = r_frame_count;
  assign byte_count      = r_byte_count;
  assign bad_frame_count = r_bad_count;
  assign runt_count      = r_runt_count;
  assign seq_error_count = r_seq_err_count;
  assign last_len        = r_last_len;
  assign seq_locked      = r_seq_locked;
  assign act_led         = r_act_led;

endmodule

// File: tb/tb_axis_rx_frame_checker.sv
// Directed bench for axis_rx_frame_checker. A frame-level model is compared
// against the DUT outputs on every cycle, with literal checks at key points.
module tb_axis_rx_frame_checker;
  localparam int unsigned LED_N    = 4;
  localparam int unsigned SEQ_WORD = 6;
  localparam int unsigned MIN_LEN  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] frame_count;
  logic [63:0] byte_count;
  logic [31:0] bad_frame_count;
  logic [31:0] runt_count;
  logic [31:0] seq_error_count;
  logic [15:0] last_len;
  logic        seq_locked;
  logic        act_led;

  axis_rx_frame_checker_if #(.DATA_WIDTH(64)) s_axis_if ();

  axis_rx_frame_checker #(
    .DATA_WIDTH(64),
    .SEQ_WORD(SEQ_WORD),
    .MIN_LEN(MIN_LEN),
    .LED_STRETCH(LED_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_axis_if),
    .clear(clear),
    .frame_count(frame_count),
    .byte_count(byte_count),
    .bad_frame_count(bad_frame_count),
    .runt_count(runt_count),
    .seq_error_count(seq_error_count),
    .last_len(last_len),
    .seq_locked(seq_locked),
    .act_led(act_led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Frame-level model
  logic [31:0] m_frames, m_bad, m_runt, m_seqerr, m_exp;
  logic [63:0] m_bytes;
  logic [15:0] m_last;
  bit          m_locked;
  bit          m_led_any;
  int          m_led_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_frames = '0; m_bad = '0; m_runt = '0; m_seqerr = '0;
    m_bytes = '0; m_last = '0; m_locked = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_exp = '0;
    m_led_any = 1'b0;
    m_led_cyc = 0;
  endtask

  task automatic model_eof(input int n, input logic [31:0] seq, input bit user,
                           input bit has_seq, input bit clr);
    if (clr) model_clear();
    if (user) begin
      m_bad = m_bad + 1;
    end else begin
      m_frames = m_frames + 1;
      m_bytes  = m_bytes + 64'(n);
      m_last   = 16'(n);
      if (n < int'(MIN_LEN)) m_runt = m_runt + 1;
      m_led_any = 1'b1;
      m_led_cyc = cyc;
      if (has_seq) begin
        if (m_locked && seq != m_exp) m_seqerr = m_seqerr + 1;
        m_locked = 1'b1;
        m_exp    = seq + 32'd1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tready", s_axis_if.tready, 1);
      chk("frame_count", frame_count, m_frames);
      chk("byte_count", byte_count, m_bytes);
      chk("bad_frame_count", bad_frame_count, m_bad);
      chk("runt_count", runt_count, m_runt);
      chk("seq_error_count", seq_error_count, m_seqerr);
      chk("last_len", last_len, m_last);
      chk("seq_locked", seq_locked, m_locked);
      chk("act_led", act_led, (m_led_any && (cyc - m_led_cyc) < int'(LED_N)));
    end
  end

  task automatic send_frame(input int n, input logic [31:0] seq, input bit user,
                            input bit clr, input int bubble_at, input int zero_at);
    logic [7:0] keeps[$];
    int rem;
    int k;
    rem = n;
    while (rem > 0) begin
      k = (rem > 8) ? 8 : rem;
      keeps.push_back(8'((1 << k) - 1));
      rem -= k;
    end
    if (zero_at >= 0 && zero_at < keeps.size()) keeps.insert(zero_at, 8'h00);
    for (int b = 0; b < keeps.size(); b++) begin
      if (b == bubble_at) begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      s_axis_if.tdata = {$urandom, $urandom};
      if (b == int'(SEQ_WORD)) s_axis_if.tdata[31:0] = seq;
      s_axis_if.tkeep  = keeps[b];
      s_axis_if.tlast  = (b == keeps.size() - 1);
      s_axis_if.tuser  = s_axis_if.tlast ? user : 1'($urandom_range(0, 1));
      clear            = s_axis_if.tlast ? clr : 1'b0;
      s_axis_if.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tuser  = 1'b0;
    clear            = 1'b0;
    model_eof(n, seq, user, keeps.size() > int'(SEQ_WORD), clr);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int led_cnt;

  initial begin
    s_axis_if.tdata  = '0;
    s_axis_if.tkeep  = '0;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tuser  = 1'b0;
    model_reset();

    // Reset and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_axis_if.tready, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_act_led", act_led, 0);
    chk("rst_seq_locked", seq_locked, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_release_cycle", s_axis_if.tready, 0);
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;

    // Ten good 64-byte frames, seq 100..109
    for (int i = 0; i < 10; i++) send_frame(64, 32'(100 + i), 1'b0, 1'b0, (i == 3) ? 2 : -1, -1);
    chk("lit_frames10", frame_count, 10);
    chk("lit_bytes640", byte_count, 640);
    chk("lit_seqerr0", seq_error_count, 0);
    chk("lit_locked", seq_locked, 1);
    chk("lit_last64", last_len, 64);
    chk("lit_runt0", runt_count, 0);

    // 61-byte frame then a 42-byte frame without a sequence beat
    send_frame(61, 32'd110, 1'b0, 1'b0, -1, -1);
    chk("lit_last61", last_len, 61);
    send_frame(42, 32'hDEAD_BEEF, 1'b0, 1'b0, -1, -1);
    chk("lit_last42", last_len, 42);
    chk("lit_runt1", runt_count, 1);
    chk("lit_seqerr_after42", seq_error_count, 0);
    chk("lit_model_exp111", m_exp, 111);

    // Gap in sequence, bad frame in between does not disturb expected
    pulse_clear();
    send_frame(64, 32'd5, 1'b0, 1'b0, -1, -1);
    send_frame(64, 32'd6, 1'b0, 1'b0, -1, -1);
    send_frame(64, 32'd8, 1'b0, 1'b0, -1, -1);
    send_frame(64, 32'd9, 1'b0, 1'b0, -1, -1);
    send_frame(64, 32'd20, 1'b1, 1'b0, -1, -1);
    send_frame(64, 32'd10, 1'b0, 1'b0, -1, -1);
    chk("lit_seqerr1", seq_error_count, 1);
    chk("lit_bad1", bad_frame_count, 1);
    chk("lit_frames5", frame_count, 5);

    // Sequence wrap, with an empty-keep beat inside one frame
    pulse_clear();
    send_frame(64, 32'hFFFF_FFFE, 1'b0, 1'b0, -1, -1);
    send_frame(64, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 2);
    send_frame(64, 32'h0000_0000, 1'b0, 1'b0, -1, -1);
    chk("lit_wrap_seqerr0", seq_error_count, 0);
    chk("lit_wrap_bytes192", byte_count, 192);
    idle(10);

    // Clear coincident with end of a 128-byte frame, then LED length
    send_frame(128, 32'd1, 1'b0, 1'b1, -1, -1);
    chk("lit_clr_frames1", frame_count, 1);
    chk("lit_clr_bytes128", byte_count, 128);
    chk("lit_clr_locked", seq_locked, 1);
    led_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (act_led) led_cnt++;
    end
    chk("lit_led_cycles4", led_cnt, 4);
    idle(2);

    // Retrigger while lit
    send_frame(8, 32'd0, 1'b0, 1'b0, -1, -1);
    idle(2);
    send_frame(8, 32'd0, 1'b0, 1'b0, -1, -1);
    led_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (act_led) led_cnt++;
    end
    chk("lit_led_retrigger4", led_cnt, 4);
    idle(2);

    // Reset mid-frame: the remaining beats form a new frame
    for (int b = 0; b < 3; b++) begin
      s_axis_if.tdata  = {$urandom, $urandom};
      s_axis_if.tkeep  = 8'hFF;
      s_axis_if.tlast  = 1'b0;
      s_axis_if.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    s_axis_if.tvalid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    model_reset();
    chk_en = 1'b1;
    send_frame(40, 32'd0, 1'b0, 1'b0, -1, -1);
    chk("lit_abort_frames1", frame_count, 1);
    chk("lit_abort_last40", last_len, 40);
    chk("lit_abort_runt1", runt_count, 1);
    idle(6);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
